// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared opcode, state and datapath-select encodings for the multi-cycle control FSM
package mc_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_EXEC_I   = 4'd3,
        ST_MEM_ADDR = 4'd4,
        ST_MEM_RD   = 4'd5,
        ST_MEM_WB   = 4'd6,
        ST_MEM_WR   = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_JAL      = 4'd9,
        ST_JALR_EX  = 4'd10,
        ST_JALR_WB  = 4'd11,
        ST_LUI      = 4'd12,
        ST_AUIPC    = 4'd13,
        ST_ALU_WB   = 4'd14,
        ST_TRAP     = 4'd15
    } state_t;

    // alu_op classes; alu_ctrl decodes these same values
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
    localparam logic [1:0] ALU_OP_ITYPE = 2'b11;

    localparam logic [1:0] SRC_A_OLD_PC = 2'b00;
    localparam logic [1:0] SRC_A_PC     = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;
    localparam logic [1:0] SRC_A_ZERO   = 2'b11;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    localparam logic PC_SRC_ALU    = 1'b0;
    localparam logic PC_SRC_ALUOUT = 1'b1;

    function automatic logic branch_taken(input logic [2:0] func3, input logic zero);
        return ((func3 == F3_BEQ) && zero) || ((func3 == F3_BNE) && !zero);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// rtl/mc_ctrl_decode.sv - combinational opcode/func3 classifier giving the state after DECODE
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    output logic [3:0] next_state,
    output logic       illegal,
    output logic       func3_bad
);

    always_comb begin
        next_state = ST_FETCH;
        illegal    = 1'b0;
        case (opcode)
            OP_R:               next_state = ST_EXEC_R;
            OP_I:               next_state = ST_EXEC_I;
            OP_LOAD, OP_STORE:  next_state = ST_MEM_ADDR;
            OP_BRANCH:          next_state = ST_BRANCH;
            OP_JAL:             next_state = ST_JAL;
            OP_JALR:            next_state = ST_JALR_EX;
            OP_LUI:             next_state = ST_LUI;
            OP_AUIPC:           next_state = ST_AUIPC;
            default:            illegal    = 1'b1;
        endcase
    end

    // Only BEQ and BNE are implemented
    assign func3_bad = !((func3 == F3_BEQ) || (func3 == F3_BNE));

endmodule

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - RV32I multi-cycle main control FSM; MC_CTRL_TRAP_EN adds the TRAP state and trap port
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       reg_write,
    output logic [1:0] wb_sel,
`ifdef MC_CTRL_TRAP_EN
    output logic       trap,
`endif
    output logic [3:0] state
);

`ifdef MC_CTRL_TRAP_EN
    localparam state_t ST_ILLEGAL = ST_TRAP;
`else
    localparam state_t ST_ILLEGAL = ST_FETCH;
`endif

    state_t     cur_state;
    state_t     nxt_state;
    logic [3:0] dispatch;
    logic       op_illegal;
    logic       func3_bad;

    mc_ctrl_decode u_decode (
        .opcode     (opcode),
        .func3      (func3),
        .next_state (dispatch),
        .illegal    (op_illegal),
        .func3_bad  (func3_bad)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= ST_FETCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = PC_SRC_ALU;
        alu_op    = ALU_OP_ADD;
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_RS2;
        reg_write = 1'b0;
        wb_sel    = WB_ALUOUT;
`ifdef MC_CTRL_TRAP_EN
        trap      = 1'b0;
`endif
        case (cur_state)
            ST_FETCH: begin
                mem_req   = 1'b1;
                alu_src_a = SRC_A_PC;
                alu_src_b = SRC_B_FOUR;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    nxt_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Branch/JAL target is precomputed into ALUOut here
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
                nxt_state = op_illegal ? ST_ILLEGAL : state_t'(dispatch);
            end
            ST_EXEC_R: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_RS2;
                alu_op    = ALU_OP_RTYPE;
                nxt_state = ST_ALU_WB;
            end
            ST_EXEC_I: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALU_OP_ITYPE;
                nxt_state = ST_ALU_WB;
            end
            ST_ALU_WB: begin
                reg_write = 1'b1;
                wb_sel    = WB_ALUOUT;
                nxt_state = ST_FETCH;
            end
            ST_MEM_ADDR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                nxt_state = (opcode == OP_LOAD) ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    nxt_state = ST_MEM_WB;
                end
            end
            ST_MEM_WB: begin
                reg_write = 1'b1;
                wb_sel    = WB_MDR;
                nxt_state = ST_FETCH;
            end
            ST_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) begin
                    nxt_state = ST_FETCH;
                end
            end
            ST_BRANCH: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_RS2;
                alu_op    = ALU_OP_SUB;
                if (func3_bad) begin
                    nxt_state = ST_ILLEGAL;
                end else begin
                    if (branch_taken(func3, alu_zero)) begin
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_ALUOUT;
                    end
                    nxt_state = ST_FETCH;
                end
            end
            ST_JAL, ST_JALR_WB: begin
                // rd receives the PC as it stands before this cycle's update
                reg_write = 1'b1;
                wb_sel    = WB_PC;
                pc_write  = 1'b1;
                pc_src    = PC_SRC_ALUOUT;
                nxt_state = ST_FETCH;
            end
            ST_JALR_EX: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                nxt_state = ST_JALR_WB;
            end
            ST_LUI: begin
                alu_src_a = SRC_A_ZERO;
                alu_src_b = SRC_B_IMM;
                nxt_state = ST_ALU_WB;
            end
            ST_AUIPC: begin
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
                nxt_state = ST_ALU_WB;
            end
            ST_TRAP: begin
`ifdef MC_CTRL_TRAP_EN
                trap      = 1'b1;
                nxt_state = ST_TRAP;
`else
                nxt_state = ST_FETCH;
`endif
            end
        endcase
    end

    assign state = cur_state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - directed self-checking bench for mc_ctrl_fsm (MC_CTRL_TRAP_EN aware)
module tb_mc_ctrl_fsm;
    import mc_ctrl_pkg::*;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic [6:0] opcode    = 7'd0;
    logic [2:0] func3     = 3'd0;
    logic       alu_zero  = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req;
    logic       mem_we;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic [1:0] alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic [3:0] state;
`ifdef MC_CTRL_TRAP_EN
    logic       trap;
`endif

    int n_cmp  = 0;
    int n_bad  = 0;
    int cyc_cnt = 0;
    int t0     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    mc_ctrl_fsm u_dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .func3     (func3),
        .alu_zero  (alu_zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .alu_op    (alu_op),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .reg_write (reg_write),
        .wb_sel    (wb_sel),
`ifdef MC_CTRL_TRAP_EN
        .trap      (trap),
`endif
        .state     (state)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Zero-wait FETCH then DECODE; returns one tick after DECODE
    task automatic fetch_decode(input logic [6:0] op, input logic [2:0] f3);
        opcode    = op;
        func3     = f3;
        mem_ready = 1'b1;
        t0        = cyc_cnt;
        #1;
        chk("fetch_state", 32'(state), 0);
        chk("fetch_ir_write", 32'(ir_write), 1);
        chk("fetch_pc_write", 32'(pc_write), 1);
        tick;
        chk("decode_state", 32'(state), 1);
        chk("decode_src_b", 32'(alu_src_b), 2);
        tick;
    endtask

    task automatic illegal_tail;
`ifdef MC_CTRL_TRAP_EN
        for (int i = 0; i < 10; i++) begin
            chk("trap_state", 32'(state), 15);
            chk("trap_flag", 32'(trap), 1);
            chk("trap_enables", 32'({mem_req, pc_write, reg_write, ir_write}), 0);
            tick;
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("trap_rst_state", 32'(state), 0);
        chk("trap_rst_flag", 32'(trap), 0);
`else
        chk("illegal_nop_state", 32'(state), 0);
`endif
    endtask

    initial begin
        rst = 1'b1;
        tick;
        tick;
        chk("rst_state", 32'(state), 0);
        chk("rst_mem_req", 32'(mem_req), 1);
        chk("rst_ir_write_gated", 32'(ir_write), 0);
        chk("rst_srcs", 32'({alu_src_a, alu_src_b}), 32'h5);
        rst = 1'b0;

        fetch_decode(OP_R, 3'd0);
        chk("r_state", 32'(state), 2);
        chk("r_alu_op", 32'(alu_op), 2);
        chk("r_no_wr", 32'(reg_write), 0);
        tick;
        chk("r_wb_state", 32'(state), 14);
        chk("r_wb_reg_write", 32'(reg_write), 1);
        tick;
        chk("r_done", 32'(state), 0);
        chk("r_latency", 32'(cyc_cnt - t0), 4);

        fetch_decode(OP_LOAD, 3'd2);
        chk("ld_addr_state", 32'(state), 4);
        chk("ld_addr_srcs", 32'({alu_src_a, alu_src_b}), 32'hA);
        mem_ready = 1'b0;
        tick;
        for (int i = 0; i < 3; i++) begin
            chk("ld_wait_state", 32'(state), 5);
            chk("ld_wait_req_we", 32'({mem_req, mem_we}), 2);
            tick;
        end
        mem_ready = 1'b1;
        #1;
        chk("ld_ready_req", 32'(mem_req), 1);
        tick;
        chk("ld_wb_state", 32'(state), 6);
        chk("ld_wb_sel", 32'(wb_sel), 1);
        chk("ld_wb_reg_write", 32'(reg_write), 1);
        tick;
        chk("ld_latency", 32'(cyc_cnt - t0), 8);

        fetch_decode(OP_STORE, 3'd2);
        tick;
        chk("st_state", 32'(state), 7);
        chk("st_req_we", 32'({mem_req, mem_we}), 3);
        tick;
        chk("st_latency", 32'(cyc_cnt - t0), 4);

        alu_zero = 1'b1;
        fetch_decode(OP_BRANCH, 3'b000);
        chk("beq_state", 32'(state), 8);
        chk("beq_alu_op", 32'(alu_op), 1);
        chk("beq_pc", 32'({pc_write, pc_src}), 3);
        tick;
        chk("beq_latency", 32'(cyc_cnt - t0), 3);

        fetch_decode(OP_BRANCH, 3'b001);
        chk("bne_pc_write", 32'(pc_write), 0);
        alu_zero = 1'b0;
        #1;
        chk("bne_taken_pc", 32'({pc_write, pc_src}), 3);
        tick;
        chk("bne_done", 32'(state), 0);

        alu_zero = 1'b1;
        fetch_decode(OP_BRANCH, 3'b100);
        chk("bad_f3_state", 32'(state), 8);
        chk("bad_f3_pc_write", 32'(pc_write), 0);
        tick;
        illegal_tail;

        fetch_decode(OP_JAL, 3'd0);
        chk("jal_state", 32'(state), 9);
        chk("jal_outputs", 32'({reg_write, wb_sel, pc_write, pc_src}), 32'h1B);
        tick;
        chk("jal_next", 32'(state), 0);
        chk("jal_latency", 32'(cyc_cnt - t0), 3);

        fetch_decode(OP_JALR, 3'd0);
        chk("jalr_ex_state", 32'(state), 10);
        chk("jalr_ex_srcs", 32'({alu_src_a, alu_src_b, alu_op}), 32'h28);
        tick;
        chk("jalr_wb_state", 32'(state), 11);
        chk("jalr_wb_outputs", 32'({reg_write, wb_sel, pc_write, pc_src}), 32'h1B);
        tick;
        chk("jalr_latency", 32'(cyc_cnt - t0), 4);

        fetch_decode(OP_LUI, 3'd0);
        chk("lui_state", 32'(state), 12);
        chk("lui_srcs", 32'({alu_src_a, alu_src_b}), 32'hE);
        tick;
        tick;
        chk("lui_latency", 32'(cyc_cnt - t0), 4);

        fetch_decode(OP_AUIPC, 3'd0);
        chk("auipc_state", 32'(state), 13);
        chk("auipc_srcs", 32'({alu_src_a, alu_src_b}), 32'h2);
        tick;
        chk("auipc_wb", 32'(state), 14);
        tick;

        fetch_decode(OP_I, 3'd0);
        chk("i_state", 32'(state), 3);
        chk("i_alu", 32'({alu_op, alu_src_a, alu_src_b}), 32'h3A);
        tick;
        tick;
        chk("i_latency", 32'(cyc_cnt - t0), 4);

        fetch_decode(7'b1111111, 3'd0);
        illegal_tail;

        mem_ready = 1'b0;
        #1;
        chk("fetch_wait_enables", 32'({ir_write, pc_write}), 0);
        tick;
        chk("fetch_wait_state", 32'(state), 0);
        chk("fetch_wait_req", 32'(mem_req), 1);

        fetch_decode(OP_STORE, 3'd2);
        mem_ready = 1'b0;
        tick;
        chk("st_abort_pre", 32'({state, mem_req, mem_we}), 32'h1F);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("st_abort_state", 32'(state), 0);
        chk("st_abort_we", 32'(mem_we), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multi-cycle main control state machine for the RV32I CPU core. Sequences each instruction through fetch, decode, execute, memory and write-back. Drives the shared ALU's `alu_op` class (consumed by `alu_ctrl`), its operand selects, and all register, PC and memory enables. Sits between the instruction register's opcode field and the single shared datapath (ALU, register file, unified memory port).

## Interface
- No parameters.
- `clk` in 1: core clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 7: IR[6:0]; valid from DECODE onward.
- `func3` in 3: IR[14:12]; used for branch condition.
- `alu_zero` in 1: ALU result-is-zero flag.
- `mem_ready` in 1: memory has completed the current request this cycle.
- `mem_req` out 1: memory request is valid.
- `mem_we` out 1: request is a write; meaningful only while `mem_req`=1.
- `ir_write` out 1: latch fetched word into IR.
- `pc_write` out 1: update PC.
- `pc_src` out 1: 0 = ALU result, 1 = ALUOut register.
- `alu_op` out 2: 00 add, 01 sub, 10 R-type, 11 I-type.
- `alu_src_a` out 2: 00 old_pc, 01 PC, 10 rs1, 11 zero.
- `alu_src_b` out 2: 00 rs2, 01 constant 4, 10 imm.
- `reg_write` out 1: register-file write enable.
- `wb_sel` out 2: 00 ALUOut, 01 memory data register, 10 PC.
- `trap` out 1: illegal instruction; present only with the trap macro.
- `state` out 4: current state encoding, for debug.

## Operation
- States and encodings:
  - FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WB=6, MEM_WR=7, BRANCH=8, JAL=9, JALR_EX=10, JALR_WB=11, LUI=12, AUIPC=13, ALU_WB=14, TRAP=15.
- All outputs are a Moore function of `state` except `ir_write`, `pc_write` and the branch qualification, which also depend on `mem_ready` or `alu_zero`.
- FETCH:
  - `mem_req`=1, `mem_we`=0, ALU computes PC+4 (src_a=01, src_b=01, op=00).
  - Wait while `mem_ready`=0.
  - On `mem_ready`=1: `ir_write`=1, `pc_write`=1, `pc_src`=0, then go to DECODE.
- DECODE:
  - ALU computes old_pc+imm into ALUOut (src_a=00, src_b=10, op=00).
  - Dispatch on opcode:
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 0000011 or 0100011 → MEM_ADDR
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR_EX
    - 0110111 → LUI
    - 0010111 → AUIPC
    - anything else → illegal
- EXEC_R: src_a=10, src_b=00, op=10, then ALU_WB.
- EXEC_I: src_a=10, src_b=10, op=11, then ALU_WB.
- ALU_WB: `reg_write`=1, `wb_sel`=00, then FETCH.
- MEM_ADDR: src_a=10, src_b=10, op=00. Go to MEM_RD for a load, MEM_WR for a store.
- MEM_RD: `mem_req`=1 until `mem_ready`, then MEM_WB.
- MEM_WB: `reg_write`=1, `wb_sel`=01, then FETCH.
- MEM_WR: `mem_req`=1, `mem_we`=1 until `mem_ready`, then FETCH.
- BRANCH:
  - src_a=10, src_b=00, op=01 (sub).
  - Taken if (func3=000 and `alu_zero`) or (func3=001 and !`alu_zero`).
  - If taken: `pc_write`=1, `pc_src`=1. Then FETCH.
  - Other func3 values are illegal.
- JAL: `reg_write`=1, `wb_sel`=10, `pc_write`=1, `pc_src`=1, then FETCH.
- JALR_EX: src_a=10, src_b=10, op=00, then JALR_WB.
- JALR_WB: same outputs as JAL, then FETCH.
- LUI: src_a=11, src_b=10, op=00, then ALU_WB.
- AUIPC: src_a=00, src_b=10, op=00, then ALU_WB.
- Inactive outputs are 0 in every state.

## Timing
- Reset:
  - `rst` sampled high → next state FETCH.
  - All outputs return to their FETCH Moore values, with `ir_write`/`pc_write` gated by `mem_ready`; `trap`=0.
  - Reset mid-request abandons the request; memory must tolerate this.
- Handshake:
  - Once `mem_req` rises, `mem_req`, `mem_we` and the address selects hold stable until the cycle `mem_ready`=1.
  - `mem_ready` is ignored outside FETCH, MEM_RD and MEM_WR.
- Latency with zero-wait memory:
  - R/I/LUI/AUIPC: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - JAL: 3 cycles.
  - JALR: 4 cycles.
- Each memory wait cycle adds 1.
- A simultaneous `pc_write` and `reg_write` (JAL/JALR_WB) writes the pre-update PC to rd.

## Configuration
- `MC_CTRL_TRAP_EN` defined:
  - An illegal opcode or branch func3 goes to TRAP.
  - TRAP asserts `trap`=1 and all enables 0, and holds until `rst`.
- Undefined:
  - Illegal instructions go from DECODE/BRANCH straight to FETCH as a NOP.
  - `trap` port is absent.
  - State 15 is unreachable; if entered, it returns to FETCH.

## Structure
- Shared package (alongside `defines.v`):
  - opcode constants
  - state encodings
  - `alu_op`, `alu_src_a`, `alu_src_b`, `wb_sel` and `pc_src` encodings
- `alu_op` encodings must match those decoded by `alu_ctrl`.
- One sub-module: `mc_ctrl_decode`, a combinational classifier mapping `opcode`/`func3` to next-state-after-DECODE plus an illegal flag.

## Test plan
- `rst`=1 for 2 cycles, then released with `mem_ready`=1, opcode 0110011 → `state` sequence 0,1,2,14,0; `alu_op`=10 in EXEC_R; `reg_write`=1 only in ALU_WB.
- Load (0000011), `mem_ready` low for 3 cycles in MEM_RD → `mem_req` held for 4 cycles with `mem_we`=0; `wb_sel`=01 in MEM_WB; total 8 cycles.
- BEQ with `alu_zero`=1 → `pc_write`=1, `pc_src`=1 in BRANCH. BNE with `alu_zero`=1 → `pc_write`=0.
- JAL → in state 9: `reg_write`=1, `wb_sel`=10, `pc_write`=1, `pc_src`=1, all in the same cycle; next state 0.
- Opcode 1111111 → with `MC_CTRL_TRAP_EN`: `state`=15 and `trap`=1, held for 10 cycles until `rst`. Without it: `state`=0 the next cycle.
- `rst` asserted in MEM_WR while `mem_req`=1 → next cycle `state`=0, `mem_we`=0.
